mac_dot_scheduler: RTL and testbench

- Shares one 12x12 unsigned multiply-accumulate unit among NREQ requesters.
- Each requester submits a dot-product job of a given length. The block grants the MAC round-robin, clears the accumulator, and streams the granted requester's operand pairs into the MAC.
- When the job finishes, it returns the 25-bit result tagged with the requester ID.
- Sits between requester clients and the MAC datapath. The MAC sync reset is integrated as reset | mac_clr.

---
 rtl/mac_dot_scheduler.sv | 126 ++++++++++++
 tb/tb_mac_dot_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_scheduler.sv
// Round-robin scheduler that shares one registered 12x12 MAC among NREQ
// dot-product requesters and returns each ID-tagged result.
module mac_dot_scheduler #(
    parameter int NREQ = 4,
    parameter int DW   = 12,
    parameter int ACCW = 25,
    parameter int LENW = 8,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*LENW-1:0] req_len,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      op_valid,
    input  logic [NREQ*DW-1:0]   op_a,
    input  logic [NREQ*DW-1:0]   op_b,
    output logic [NREQ-1:0]      op_ready,
    output logic [DW-1:0]        mac_a,
    output logic [DW-1:0]        mac_b,
    output logic                 mac_clr,
    input  logic [ACCW-1:0]      mac_acc,
    output logic                 res_valid,
    output logic [ACCW-1:0]      res_data,
    output logic [IDW-1:0]       res_id,
    input  logic                 res_ready
);

    // state   | meaning
    // S_IDLE  | arbitrate pending requests, pulse req_ready of the winner
    // S_CLEAR | clear MAC accumulator, reset pair counter
    // S_RUN   | stream granted requester's operand pairs into the MAC
    // S_DRAIN | mac inputs zero while the last product lands in mac_acc
    // S_DONE  | present registered result until res_ready
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t          state, state_nx;
    logic [IDW-1:0]  gid, last_grant, grant_id, idx;
    logic            grant_found;
    logic [LENW-1:0] len, cnt;
    logic            xfer;

    // Round-robin search starting just after the last completed grant.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(last_grant) + 1 + k) % NREQ);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
    end

    assign xfer = (state == S_RUN) && op_valid[gid] && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            gid        <= '0;
            len        <= '0;
            cnt        <= '0;
            last_grant <= IDW'(NREQ - 1);
            res_data   <= '0;
            res_id     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        gid <= grant_id;
                        len <= req_len[int'(grant_id)*LENW +: LENW];
                    end
                end
                S_CLEAR: cnt <= '0;
                S_RUN:   if (xfer) cnt <= cnt + LENW'(1);
                S_DRAIN: begin
                    res_data <= mac_acc;
                    res_id   <= gid;
                end
                S_DONE:  if (res_ready) last_grant <= gid;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (grant_found) state_nx = S_CLEAR;
            S_CLEAR: state_nx = (len != '0) ? S_RUN : S_DRAIN;
            S_RUN:   if (xfer && (cnt == len - LENW'(1))) state_nx = S_DRAIN;
            S_DRAIN: state_nx = S_DONE;
            S_DONE:  if (res_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are forced low while reset is asserted so an aborted job leaves no trace.
    always_comb begin
        req_ready = '0;
        op_ready  = '0;
        mac_a     = '0;
        mac_b     = '0;
        mac_clr   = 1'b0;
        res_valid = 1'b0;
        if (!reset) begin
            case (state)
                S_IDLE:  if (grant_found) req_ready[grant_id] = 1'b1;
                S_CLEAR: mac_clr = 1'b1;
                S_RUN: begin
                    op_ready[gid] = 1'b1;
                    if (xfer) begin
                        mac_a = op_a[int'(gid)*DW +: DW];
                        mac_b = op_b[int'(gid)*DW +: DW];
                    end
                end
                S_DONE:  res_valid = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_scheduler.sv
// Scoreboard bench for mac_dot_scheduler with a behavioural registered MAC.
module tb_mac_dot_scheduler;
    localparam int NREQ = 4, DW = 12, ACCW = 25, LENW = 8, IDW = 2;

    logic                 clk, reset;
    logic [NREQ-1:0]      req_valid, req_ready, op_valid, op_ready;
    logic [NREQ*LENW-1:0] req_len;
    logic [NREQ*DW-1:0]   op_a, op_b;
    logic [DW-1:0]        mac_a, mac_b;
    logic                 mac_clr, res_valid, res_ready;
    logic [ACCW-1:0]      mac_acc, res_data;
    logic [IDW-1:0]       res_id;

    mac_dot_scheduler #(.NREQ(NREQ), .DW(DW), .ACCW(ACCW), .LENW(LENW), .IDW(IDW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
        .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
        .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .mac_acc(mac_acc),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MAC: registered accumulator, sync clear on reset | mac_clr.
    always @(posedge clk) begin
        if (reset || mac_clr) mac_acc <= '0;
        else                  mac_acc <= mac_acc + ACCW'(mac_a) * ACCW'(mac_b);
    end

    typedef struct packed { logic v; logic [DW-1:0] a; logic [DW-1:0] b; } op_t;
    typedef struct packed { logic [IDW-1:0] id; logic [ACCW-1:0] data; } res_t;

    op_t            opq [NREQ][$];
    res_t           exp_q[$];
    logic [IDW-1:0] grant_q[$];
    int             jobs_left[NREQ];
    logic [LENW-1:0] lens[NREQ];
    int             tests = 0, fails = 0;
    int             cycle = 0, t_grant = 0, exp_lat = -1, xfer_total = 0;
    int             opr_cnt[NREQ];

    task automatic check(input string nm, input longint got, input longint want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, want, cycle);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_op(input int r, input logic v, input int a, input int b);
        op_t e;
        e.v = v;
        e.a = DW'(a);
        e.b = DW'(b);
        opq[r].push_back(e);
    endtask

    task automatic issue(input int r, input int n, input int njobs, input int exp_data, input int k);
        lens[r] = LENW'(n);
        jobs_left[r] = njobs;
        for (int j = 0; j < k; j++) begin
            grant_q.push_back(IDW'(r));
            exp_q.push_back('{id: IDW'(r), data: ACCW'(exp_data)});
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || grant_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check("wait_done_timeout", exp_q.size() + grant_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int r = 0; r < NREQ; r++) begin
            opq[r].delete();
            jobs_left[r] = 0;
        end
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_op_ready"}, op_ready, 0);
        check({tag, "_mac_a"}, mac_a, 0);
        check({tag, "_mac_b"}, mac_b, 0);
        check({tag, "_mac_clr"}, mac_clr, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_data"}, res_data, 0);
        check({tag, "_res_id"}, res_id, 0);
    endtask

    // Requester model: presents queued operands and pending jobs.
    initial begin
        logic [NREQ-1:0] xf, rr, ordy;
        req_valid = '0; req_len = '0; op_valid = '0; op_a = '0; op_b = '0;
        forever begin
            @(negedge clk);
            xf = op_valid & op_ready;
            rr = req_ready;
            ordy = op_ready;
            @(posedge clk);
            #1;
            for (int r = 0; r < NREQ; r++) begin
                if (opq[r].size() > 0 && (xf[r] || (ordy[r] && !opq[r][0].v)))
                    void'(opq[r].pop_front());
                if (rr[r] && jobs_left[r] > 0) jobs_left[r]--;
                req_valid[r] = (jobs_left[r] > 0);
                req_len[r*LENW +: LENW] = lens[r];
                op_valid[r] = (opq[r].size() > 0) && opq[r][0].v;
                op_a[r*DW +: DW] = (opq[r].size() > 0) ? opq[r][0].a : '0;
                op_b[r*DW +: DW] = (opq[r].size() > 0) ? opq[r][0].b : '0;
            end
        end
    end

    // Monitor: grants, MAC inputs, result hold and result scoreboard.
    initial begin
        logic [NREQ-1:0] xfm;
        logic [IDW-1:0]  eg;
        res_t            er;
        logic            prev_valid, prev_ready;
        logic [ACCW-1:0] prev_data;
        logic [IDW-1:0]  prev_id;
        prev_valid = 1'b0; prev_ready = 1'b1; prev_data = '0; prev_id = '0;
        forever begin
            @(negedge clk);
            cycle++;
            if (reset) begin
                prev_valid = 1'b0;
                continue;
            end
            if (req_ready != '0) begin
                check("req_ready_onehot", $countones(req_ready), 1);
                if (grant_q.size() == 0) begin
                    check("unexpected_grant", req_ready, 0);
                end else begin
                    eg = grant_q.pop_front();
                    check("grant_id", req_ready, 1 << eg);
                end
                t_grant = cycle;
            end
            for (int r = 0; r < NREQ; r++) if (op_ready[r]) opr_cnt[r]++;
            xfm = op_valid & op_ready;
            if (xfm == '0) begin
                check("mac_a_idle", mac_a, 0);
                check("mac_b_idle", mac_b, 0);
            end else begin
                for (int r = 0; r < NREQ; r++) begin
                    if (xfm[r]) begin
                        xfer_total++;
                        if (opq[r].size() > 0) begin
                            check("mac_a_xfer", mac_a, opq[r][0].a);
                            check("mac_b_xfer", mac_b, opq[r][0].b);
                        end
                    end
                end
            end
            if (res_valid && !prev_valid && exp_lat >= 0)
                check("latency", cycle - t_grant, exp_lat);
            if (prev_valid && !prev_ready) begin
                check("hold_valid", res_valid, 1);
                check("hold_data", res_data, prev_data);
                check("hold_id", res_id, prev_id);
            end
            if (res_valid && req_ready != '0) check("grant_during_done", req_ready, 0);
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result_id", res_id, 0);
                    check("unexpected_result", 1, 0);
                end else begin
                    er = exp_q.pop_front();
                    check("res_id", res_id, er.id);
                    check("res_data", res_data, er.data);
                end
            end
            prev_valid = res_valid;
            prev_ready = res_ready;
            prev_data  = res_data;
            prev_id    = res_id;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before 300000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        reset = 1'b1;
        res_ready = 1'b1;
        for (int r = 0; r < NREQ; r++) begin
            lens[r] = '0;
            jobs_left[r] = 0;
            opr_cnt[r] = 0;
        end
        do_reset();
        check_all_zero("reset");

        // Job of 3 pairs on requester 0: 1*2 + 3*4 + 5*6 = 44.
        exp_lat = 6;
        push_op(0, 1'b1, 1, 2); push_op(0, 1'b1, 3, 4); push_op(0, 1'b1, 5, 6);
        issue(0, 3, 1, 44, 1);
        wait_done(100);

        // All requesters, len 1, pair (2,3): grants 0,1,2,3,0.
        do_reset();
        exp_lat = 4;
        for (int r = 0; r < NREQ; r++) push_op(r, 1'b1, 2, 3);
        push_op(0, 1'b1, 2, 3);
        lens[0] = 8'd1; jobs_left[0] = 2;
        for (int r = 1; r < NREQ; r++) begin lens[r] = 8'd1; jobs_left[r] = 1; end
        for (int r = 0; r < NREQ; r++) begin
            grant_q.push_back(IDW'(r));
            exp_q.push_back('{id: IDW'(r), data: ACCW'(6)});
        end
        grant_q.push_back(IDW'(0));
        exp_q.push_back('{id: IDW'(0), data: ACCW'(6)});
        wait_done(200);

        // Requester 2 with operand gaps; 4095*4095 + 10*10.
        exp_lat = -1;
        push_op(2, 1'b1, 4095, 4095); push_op(2, 1'b0, 0, 0);
        push_op(2, 1'b0, 0, 0);       push_op(2, 1'b1, 10, 10);
        issue(2, 2, 1, 16769125, 1);
        wait_done(100);

        // Zero-length job on requester 1.
        exp_lat = 3;
        opr_cnt[1] = 0;
        issue(1, 0, 1, 0, 1);
        wait_done(100);
        check("len0_op_ready_cycles", opr_cnt[1], 0);

        // Result held with res_ready low; requester 3 waits behind requester 2.
        exp_lat = -1;
        res_ready = 1'b0;
        push_op(2, 1'b1, 7, 9);
        push_op(3, 1'b1, 2, 2);
        issue(2, 1, 1, 63, 1);
        issue(3, 1, 1, 4, 1);
        n = 0;
        while (!res_valid && n < 50) begin tick(); n++; end
        if (n >= 50) check("hold_wait_timeout", res_valid, 1);
        repeat (5) tick();
        check("hold_res_valid_end", res_valid, 1);
        res_ready = 1'b1;
        wait_done(100);

        // Reset during RUN after 2 of 4 transfers, then re-issue.
        exp_lat = -1;
        base = xfer_total;
        for (int i = 1; i <= 4; i++) push_op(3, 1'b1, i, i);
        lens[3] = 8'd4; jobs_left[3] = 1;
        grant_q.push_back(IDW'(3));
        n = 0;
        while (xfer_total < base + 2 && n < 50) begin tick(); n++; end
        if (n >= 50) check("run_wait_timeout", xfer_total - base, 2);
        reset = 1'b1;
        opq[3].delete();
        jobs_left[3] = 0;
        tick();
        reset = 1'b0;
        check_all_zero("abort");
        exp_lat = 7;
        for (int i = 1; i <= 4; i++) push_op(3, 1'b1, i, i);
        issue(3, 4, 1, 30, 1);
        wait_done(100);

        repeat (3) tick();
        check("leftover_expected", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
